// File: rtl/meta_multicast_fifo.sv
// Multicast metadata FIFO: one producer, NrConsumers independent readers.
// Each pushed entry carries a per-consumer pending mask; an entry is freed
// once every consumer it was addressed to has taken it. Consumers skip entries
// not addressed to them, so a slow reader only stalls the others once the
// buffer fills up.
module meta_multicast_fifo #(
  parameter int  NrConsumers = 2,
  parameter int  Depth       = 4,
  parameter type meta_glb_t  = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         meta_info_valid_i,
  output logic                         meta_info_ready_o,
  input  meta_glb_t                    meta_info_i,
  input  logic [NrConsumers-1:0]       cons_en_i,
  output logic [NrConsumers-1:0]       cons_valid_o,
  input  logic [NrConsumers-1:0]       cons_ready_i,
  output meta_glb_t                    cons_o [NrConsumers],
  output logic [$clog2(Depth+1)-1:0]   occupancy_o
);

  localparam int IdxW = $clog2(Depth);
  localparam int PtrW = IdxW + 1;
  localparam int OccW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;

  meta_glb_t              mem  [Depth];
  logic [NrConsumers-1:0] pend [Depth];

  ptr_t wptr;
  ptr_t hptr;
  ptr_t rptr [NrConsumers];
  ptr_t occ;

  logic full;
  logic push;
  logic free;

  logic [NrConsumers-1:0] avail;
  logic [NrConsumers-1:0] hit;
  logic [NrConsumers-1:0] hs;
  logic [NrConsumers-1:0] adv;

  // Full when indices match but the wrap bits differ.
  assign full = (wptr[IdxW-1:0] == hptr[IdxW-1:0]) && (wptr[IdxW] != hptr[IdxW]);
  assign occ  = wptr - hptr;

  assign meta_info_ready_o = !rst_i && !full;
  assign occupancy_o       = rst_i ? '0 : OccW'(occ);

  assign push = meta_info_valid_i && meta_info_ready_o;
  // Head entry is released once no consumer still owes it a handshake.
  assign free = (hptr != wptr) && (pend[hptr[IdxW-1:0]] == '0);

  // Per-consumer presentation: valid only for entries addressed to it, skip the rest.
  always_comb begin
    avail        = '0;
    hit          = '0;
    cons_valid_o = '0;
    hs           = '0;
    adv          = '0;
    for (int c = 0; c < NrConsumers; c++) begin
      avail[c]        = (rptr[c] != wptr);
      hit[c]          = avail[c] && pend[rptr[c][IdxW-1:0]][c];
      cons_valid_o[c] = hit[c] && !rst_i;
      hs[c]           = cons_valid_o[c] && cons_ready_i[c];
      adv[c]          = hs[c] || (avail[c] && !hit[c]);
      cons_o[c]       = mem[rptr[c][IdxW-1:0]];
    end
  end

  // Payload storage; a slot is only written while it is free, so pending data stays put.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr[IdxW-1:0]] <= meta_info_i;
    end
  end

  // Pointer and pending-mask bookkeeping; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      hptr <= '0;
      for (int c = 0; c < NrConsumers; c++) begin
        rptr[c] <= '0;
      end
      for (int e = 0; e < Depth; e++) begin
        pend[e] <= '0;
      end
    end else begin
      // The slot at wptr is never one a consumer is still reading, so the
      // push write and the handshake clears below never touch the same entry.
      if (push) begin
        pend[wptr[IdxW-1:0]] <= cons_en_i;
        wptr                 <= wptr + ptr_t'(1);
      end
      for (int c = 0; c < NrConsumers; c++) begin
        if (hs[c]) begin
          pend[rptr[c][IdxW-1:0]][c] <= 1'b0;
        end
        if (adv[c]) begin
          rptr[c] <= rptr[c] + ptr_t'(1);
        end
      end
      if (free) begin
        hptr <= hptr + ptr_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_meta_multicast_fifo.sv
// Bench for meta_multicast_fifo with two consumers, depth 4, byte payloads.
// Stimulus pushes expected payloads into per-consumer queues; a negedge monitor
// pops and compares on every consumer handshake.
module tb_meta_multicast_fifo;

  typedef logic [7:0] data_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       meta_info_valid_i = 1'b0;
  logic       meta_info_ready_o;
  data_t      meta_info_i = '0;
  logic [1:0] cons_en_i = '0;
  logic [1:0] cons_valid_o;
  logic [1:0] cons_ready_i = '0;
  data_t      cons_o [2];
  logic [2:0] occupancy_o;

  int n_cmp = 0;
  int n_err = 0;

  data_t exp_q0[$];
  data_t exp_q1[$];

  meta_multicast_fifo #(
    .NrConsumers(2),
    .Depth      (4),
    .meta_glb_t (data_t)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .meta_info_valid_i(meta_info_valid_i),
    .meta_info_ready_o(meta_info_ready_o),
    .meta_info_i      (meta_info_i),
    .cons_en_i        (cons_en_i),
    .cons_valid_o     (cons_valid_o),
    .cons_ready_i     (cons_ready_i),
    .cons_o           (cons_o),
    .occupancy_o      (occupancy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  // Monitor: every handshake must match the next expected payload of that consumer.
  always @(negedge clk) begin : mon
    data_t e;
    logic  ok;
    if (!rst_i) begin
      for (int c = 0; c < 2; c++) begin
        if (cons_valid_o[c] && cons_ready_i[c]) begin
          ok = 1'b0;
          e  = '0;
          if (c == 0 && exp_q0.size() > 0) begin
            e  = exp_q0.pop_front();
            ok = 1'b1;
          end else if (c == 1 && exp_q1.size() > 0) begin
            e  = exp_q1.pop_front();
            ok = 1'b1;
          end
          n_cmp++;
          if (!ok) begin
            n_err++;
            $display("FAIL unexpected_data_c%0d: got %h, expected nothing", c, cons_o[c]);
          end else if (cons_o[c] !== e) begin
            n_err++;
            $display("FAIL data_c%0d: got %h, expected %h", c, cons_o[c], e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One producer cycle; the payload is queued for its enabled consumers if accepted.
  task automatic push_cycle(input data_t d, input logic [1:0] en, output logic acc);
    meta_info_valid_i = 1'b1;
    meta_info_i       = d;
    cons_en_i         = en;
    @(negedge clk);
    acc = meta_info_ready_o;
    if (acc) begin
      if (en[0]) exp_q0.push_back(d);
      if (en[1]) exp_q1.push_back(d);
    end
    @(posedge clk);
    #1;
    meta_info_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    cons_ready_i = 2'b11;
    repeat (12) tick();
    check({name, "_occ"}, 32'(occupancy_o), 0);
    check({name, "_left_c0"}, exp_q0.size(), 0);
    check({name, "_left_c1"}, exp_q1.size(), 0);
  endtask

  initial begin : stim
    logic acc;
    int   sent;
    int   tries;

    // Reset held: everything quiet.
    rst_i = 1'b1;
    repeat (2) tick();
    check("rst_ready", 32'(meta_info_ready_o), 0);
    check("rst_valid", 32'(cons_valid_o), 0);
    check("rst_occ", 32'(occupancy_o), 0);
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", 32'(meta_info_ready_o), 1);

    // A then B to both consumers, both ready.
    cons_ready_i = 2'b11;
    push_cycle(8'hA1, 2'b11, acc);
    check("a_acc", 32'(acc), 1);
    check("a_valid_t1", 32'(cons_valid_o), 2'b11);
    check("a_data0_t1", 32'(cons_o[0]), 32'h A1);
    check("a_data1_t1", 32'(cons_o[1]), 32'h A1);
    push_cycle(8'hB2, 2'b11, acc);
    check("b_acc", 32'(acc), 1);
    check("b_valid_t2", 32'(cons_valid_o), 2'b11);
    check("b_data0_t2", 32'(cons_o[0]), 32'h B2);
    tick();
    tick();
    check("ab_occ_t4", 32'(occupancy_o), 0);

    // Consumer 1 stalled: consumer 0 drains, buffer fills, one c1 handshake reopens it.
    cons_ready_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      push_cycle(data_t'(8'hC0 + i), 2'b11, acc);
      check("c_acc", 32'(acc), 1);
    end
    tick();
    tick();
    check("c_full_occ", 32'(occupancy_o), 4);
    check("c_full_ready", 32'(meta_info_ready_o), 0);
    check("c_full_valid", 32'(cons_valid_o), 2'b10);
    check("c_head_data1", 32'(cons_o[1]), 32'h C0);
    cons_ready_i = 2'b11;
    tick();
    cons_ready_i = 2'b01;
    check("c_ready_plus1", 32'(meta_info_ready_o), 0);
    tick();
    check("c_ready_plus2", 32'(meta_info_ready_o), 1);
    check("c_occ_plus2", 32'(occupancy_o), 3);
    drain("c");

    // Per-consumer enables: X to c0 only, Y to c1 only, Z to nobody.
    cons_ready_i = 2'b11;
    push_cycle(8'h11, 2'b01, acc);
    push_cycle(8'h22, 2'b10, acc);
    push_cycle(8'h5A, 2'b00, acc);
    check("z_acc", 32'(acc), 1);
    check("z_not_valid_a", 32'(cons_valid_o), 0);
    tick();
    check("z_not_valid_b", 32'(cons_valid_o), 0);
    drain("xyz");

    // Full buffer released by c1 while the producer pushes in the same cycle as a free.
    cons_ready_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      push_cycle(data_t'(8'hF0 + i), 2'b11, acc);
    end
    tick();
    tick();
    check("f_full_occ", 32'(occupancy_o), 4);
    check("f_full_ready", 32'(meta_info_ready_o), 0);
    cons_ready_i = 2'b11;
    tick();
    check("f_occ_plus1", 32'(occupancy_o), 4);
    check("f_ready_plus1", 32'(meta_info_ready_o), 0);
    tick();
    check("f_occ_plus2", 32'(occupancy_o), 3);
    push_cycle(8'hE0, 2'b11, acc);
    check("f_push_acc", 32'(acc), 1);
    check("f_push_free_occ", 32'(occupancy_o), 3);
    drain("f");

    // Reset in the middle of traffic with three entries pending.
    cons_ready_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      push_cycle(data_t'(8'h31 + i), 2'b11, acc);
    end
    check("r_occ_before", 32'(occupancy_o), 3);
    rst_i        = 1'b1;
    cons_ready_i = 2'b11;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    check("r_in_ready", 32'(meta_info_ready_o), 0);
    check("r_in_valid", 32'(cons_valid_o), 0);
    tick();
    rst_i = 1'b0;
    #1;
    check("r_after_valid", 32'(cons_valid_o), 0);
    check("r_after_occ", 32'(occupancy_o), 0);
    check("r_after_ready", 32'(meta_info_ready_o), 1);
    drain("r");

    // Random enables and readies across several wraps.
    sent  = 0;
    tries = 0;
    while (sent < 20 && tries < 400) begin
      cons_ready_i = 2'($urandom_range(0, 3));
      push_cycle(data_t'(8'h40 + sent), 2'($urandom_range(0, 3)), acc);
      if (acc) sent++;
      tries++;
    end
    check("rnd_sent", sent, 20);
    drain("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
